board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Upstream feeder of the move-ray transmitter.
- On a start pulse, walks the 64 board squares in a board RAM in index order (0..63).
- Skips empty squares and opponent pieces.
- Presents each engine-owned piece as {piece_reg, pos_reg, engine_color} through a valid/ready handshake, then pulses done.

Parameters:
- SQUARES, 64, number of board squares scanned; must be a power of two.
- ADDR_W, 6, square index width; log2(SQUARES).
- PIECE_W, 6, piece code width: bit5 = colour (1 = WHITE, 0 = BLACK), bits4:0 = type.
- CNT_W, 7, piece counter width; holds 0..SQUARES.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle scan request; ignored unless IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done pulse
- color_in  in  1  engine colour, sampled on accepted start
- rd_en  out  1  board RAM read strobe
- rd_addr  out  ADDR_W  board RAM read address
- rd_data  in  PIECE_W  piece code; valid exactly one cycle after rd_en=1
- engine_color  out  1  latched colour for the transmitter
- piece_reg  out  PIECE_W  current piece; 0 whenever out_valid=0
- pos_reg  out  ADDR_W  square index of piece_reg
- out_valid  out  1  piece_reg/pos_reg valid
- out_ready  in  1  downstream accepts the piece when out_valid & out_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at scan completion
- piece_count  out  CNT_W  own pieces emitted in current/last scan

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; idx = 0.
  - All outputs 0: rd_en, rd_addr, engine_color, piece_reg, pos_reg, out_valid, busy, done, piece_count.
- All outputs are registered. Own piece is defined as rd_data[4:0] != 5'b00000 && rd_data[5] == engine_color.
- FSM states: IDLE, REQ, EVAL, HOLD, DONE.
- IDLE, start=1:
  - Latch engine_color = color_in; idx = 0; piece_count = 0.
  - Next cycle: rd_en = 1, rd_addr = 0; go to REQ.
- REQ: rd_en is high this cycle with rd_addr = idx. Go to EVAL; rd_en drops.
- EVAL (rd_data valid):
  - Own piece: piece_reg = rd_data, pos_reg = idx, out_valid = 1, piece_count + 1; go to HOLD.
  - Otherwise, idx == SQUARES-1: go to DONE.
  - Otherwise: idx + 1; go to REQ.
- HOLD:
  - out_valid, piece_reg and pos_reg are held stable until out_valid & out_ready.
  - On accept: out_valid = 0, piece_reg = 0, pos_reg = 0. Then go to DONE if idx == SQUARES-1, else idx + 1 and go to REQ.
  - out_ready while out_valid=0 has no effect.
- DONE: done = 1 for exactly one cycle; busy = 0 the following cycle; return to IDLE.
  - piece_count and engine_color hold until the next accepted start.
- Throughput:
  - Skipped square: 2 cycles.
  - Own piece with out_ready held high: 3 cycles.
  - Empty board: start to done = 1 + 128 cycles.
- Boundaries:
  - start while busy: ignored, no state change.
  - start and done in the same cycle: start ignored.
  - abort in any non-IDLE state: next cycle IDLE; out_valid = 0, piece_reg = 0, rd_en = 0, done = 0; piece_count holds its partial value.
  - abort and start together in IDLE: abort wins; stay IDLE.
  - idx never wraps; a scan ends at SQUARES-1.
  - Square 63 holding an own piece: done follows its acceptance only.
  - Reset mid-scan: immediate return to the reset state; RAM is not read again.
  - rd_data is sampled only in EVAL; other cycles are don't-care.

Test Plan:
- Empty board, color_in=1, out_ready=1 -> out_valid never high; done pulses exactly 129 cycles after start; piece_count = 0; rd_addr sequence 0..63.
- White pawn 6'b100010 at sq 8, black knight 6'b000001 at sq 10, color_in=1 -> exactly one handshake: piece_reg = 6'b100010, pos_reg = 8; piece_count = 1.
- White rook 6'b110000 at sq 0 and sq 63, out_ready low 5 cycles -> piece_reg and pos_reg stable while stalled; both pieces emitted; done one cycle after sq 63 accept; piece_count = 2.
- Black queen 6'b011000 at sq 20, color_in=0, abort asserted while in HOLD -> next cycle out_valid = 0, piece_reg = 0, IDLE, no done; piece_count = 1.
- start pulsed again mid-scan -> ignored; scan order and piece_count unchanged versus a reference scan.
- reset_n low asynchronously mid-REQ -> all outputs 0 immediately; new start produces a full fresh scan from sq 0.

Source files
------------

// File: rtl/board_scanner_if.sv
// Board scanner bus: board RAM read port plus the piece stream to the
// move-ray transmitter. The scanner is the master of both halves.
interface board_scanner_if #(
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 6
);
    // Board RAM read port
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIECE_W-1:0] rd_data;

    // Piece stream towards the transmitter
    logic               engine_color;
    logic [PIECE_W-1:0] piece_reg;
    logic [ADDR_W-1:0]  pos_reg;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output rd_en, rd_addr, engine_color, piece_reg, pos_reg, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, engine_color, piece_reg, pos_reg, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/board_scanner.sv
// Board scanner: walks every board square in index order, skips empty squares
// and opponent pieces, and streams each engine-owned piece with its square
// index through a valid/ready handshake. A one-cycle done pulse closes a scan.
module board_scanner #(
    parameter int SQUARES = 64,
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 6,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             color_in,
    board_scanner_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] piece_count
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SQUARES - 1);

    logic [2:0]         state_r;
    logic [ADDR_W-1:0]  idx_r;
    logic               rd_en_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic               engine_color_r;
    logic [PIECE_W-1:0] piece_r;
    logic [ADDR_W-1:0]  pos_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   piece_count_r;

    logic               own_piece_s;
    logic               last_sq_s;
    logic               accept_s;

    // Classify the square just read and the handshake / end-of-board conditions
    always_comb begin
        own_piece_s = 1'b0;
        last_sq_s   = 1'b0;
        accept_s    = 1'b0;
        if ((bus.rd_data[PIECE_W-2:0] != {(PIECE_W-1){1'b0}}) &&
            (bus.rd_data[PIECE_W-1] == engine_color_r)) begin
            own_piece_s = 1'b1;
        end else begin
            own_piece_s = 1'b0;
        end
        if (idx_r == LAST_IDX) begin
            last_sq_s = 1'b1;
        end else begin
            last_sq_s = 1'b0;
        end
        if (out_valid_r && bus.out_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Scan FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            idx_r          <= {ADDR_W{1'b0}};
            rd_en_r        <= 1'b0;
            rd_addr_r      <= {ADDR_W{1'b0}};
            engine_color_r <= 1'b0;
            piece_r        <= {PIECE_W{1'b0}};
            pos_r          <= {ADDR_W{1'b0}};
            out_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            piece_count_r  <= {CNT_W{1'b0}};
        end else if (abort && (state_r != ST_IDLE)) begin
            // Abort drops any pending piece; the partial count stays visible
            state_r     <= ST_IDLE;
            rd_en_r     <= 1'b0;
            piece_r     <= {PIECE_W{1'b0}};
            pos_r       <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        engine_color_r <= color_in;
                        idx_r          <= {ADDR_W{1'b0}};
                        piece_count_r  <= {CNT_W{1'b0}};
                        rd_en_r        <= 1'b1;
                        rd_addr_r      <= {ADDR_W{1'b0}};
                        busy_r         <= 1'b1;
                        state_r        <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    rd_en_r <= 1'b0;
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (own_piece_s) begin
                        piece_r       <= bus.rd_data;
                        pos_r         <= idx_r;
                        out_valid_r   <= 1'b1;
                        piece_count_r <= piece_count_r + CNT_W'(1);
                        state_r       <= ST_HOLD;
                    end else if (last_sq_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r     <= idx_r + ADDR_W'(1);
                        rd_addr_r <= idx_r + ADDR_W'(1);
                        rd_en_r   <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b0;
                        piece_r     <= {PIECE_W{1'b0}};
                        pos_r       <= {ADDR_W{1'b0}};
                        if (last_sq_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r     <= idx_r + ADDR_W'(1);
                            rd_addr_r <= idx_r + ADDR_W'(1);
                            rd_en_r   <= 1'b1;
                            state_r   <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rd_en_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    piece_r     <= {PIECE_W{1'b0}};
                    pos_r       <= {ADDR_W{1'b0}};
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en        = rd_en_r;
    assign bus.rd_addr      = rd_addr_r;
    assign bus.engine_color = engine_color_r;
    assign bus.piece_reg    = piece_r;
    assign bus.pos_reg      = pos_r;
    assign bus.out_valid    = out_valid_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign piece_count      = piece_count_r;
endmodule

// File: tb/tb_board_scanner.sv
// Testbench for board_scanner: board RAM model, handshake monitor and a
// square-by-square reference model of which pieces a scan must emit.
module tb_board_scanner;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       color_in;
    logic       busy;
    logic       done;
    logic [6:0] piece_count;

    board_scanner_if bif ();

    board_scanner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .color_in    (color_in),
        .bus         (bif),
        .busy        (busy),
        .done        (done),
        .piece_count (piece_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  board [64];
    int          addr_q [$];
    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Board RAM model: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (bif.rd_en) begin
            bif.rd_data <= board[bif.rd_addr];
            addr_q.push_back(int'(bif.rd_addr));
        end else begin
            bif.rd_data <= 6'($urandom);
        end
    end

    // Handshake monitor: zero piece when idle, stability while stalled, capture
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [5:0] pp = 6'd0;
    logic [5:0] ps = 6'd0;
    always @(negedge clk) begin
        if (!bif.out_valid) chk("piece_zero_when_invalid", 32'(bif.piece_reg), 32'd0);
        if (pv && !pr && bif.out_valid) begin
            chk("stall_piece_stable", 32'(bif.piece_reg), 32'(pp));
            chk("stall_pos_stable", 32'(bif.pos_reg), 32'(ps));
        end
        if (bif.out_valid && bif.out_ready) got_q.push_back({bif.piece_reg, bif.pos_reg});
        pv = bif.out_valid;
        pr = bif.out_ready;
        pp = bif.piece_reg;
        ps = bif.pos_reg;
    end

    // Reference: own piece = non-zero type with colour bit equal to engine colour
    function automatic void build_exp(input logic clr);
        exp_q.delete();
        for (int sq = 0; sq < 64; sq++) begin
            if ((board[sq][4:0] != 5'd0) && (board[sq][5] == clr))
                exp_q.push_back({board[sq], 6'(sq)});
        end
    endfunction

    task automatic clear_board();
        for (int sq = 0; sq < 64; sq++) board[sq] = 6'd0;
    endtask

    task automatic random_board();
        for (int sq = 0; sq < 64; sq++) begin
            case ($urandom_range(0, 3))
                0:       board[sq] = 6'd0;
                1:       board[sq] = 6'b100000;
                default: board[sq] = {1'($urandom), 5'($urandom_range(1, 31))};
            endcase
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bif.rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bif.rd_addr), 32'd0);
        chk({tag, "_engine_color"}, 32'(bif.engine_color), 32'd0);
        chk({tag, "_piece_reg"}, 32'(bif.piece_reg), 32'd0);
        chk({tag, "_pos_reg"}, 32'(bif.pos_reg), 32'd0);
        chk({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_piece_count"}, 32'(piece_count), 32'd0);
    endtask

    // rmode: 0 ready high, 1 random ready, 2 five-cycle stall per piece
    task automatic run_scan(input logic clr, input int rmode, input int mid_start,
                            input bit start_at_done, output int cyc, output int acc63);
        bit   seen;
        bit   prev_acc;
        logic [5:0] prev_pos;
        int   stall;
        seen = 1'b0; prev_acc = 1'b0; prev_pos = 6'd0; stall = 0; cyc = 0; acc63 = -1;
        got_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        color_in = clr;
        start = 1'b1;
        bif.out_ready = (rmode == 0);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (cyc == mid_start) start = 1'b1;
            if (prev_acc && (prev_pos == 6'd63)) acc63 = cyc - 1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            case (rmode)
                0: bif.out_ready = 1'b1;
                1: bif.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!bif.out_valid) begin
                        stall = 0;
                        bif.out_ready = 1'b0;
                    end else if (stall < 5) begin
                        stall++;
                        bif.out_ready = 1'b0;
                    end else begin
                        bif.out_ready = 1'b1;
                    end
                end
            endcase
            prev_acc = bif.out_valid && bif.out_ready;
            prev_pos = bif.pos_reg;
        end
        chk("done_within_budget", 32'(seen), 32'd1);
        chk("busy_in_done_cycle", 32'(busy), 32'd1);
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("idle_no_read", 32'(bif.rd_en), 32'd0);
        chk("idle_busy_low", 32'(busy), 32'd0);
    endtask

    task automatic check_results(input logic clr, input string tag);
        build_exp(clr);
        chk({tag, "_n_pieces"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_piece_pos"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_piece_count"}, 32'(piece_count), 32'(exp_q.size()));
        chk({tag, "_engine_color"}, 32'(bif.engine_color), 32'(clr));
        chk({tag, "_n_reads"}, 32'(addr_q.size()), 32'd64);
        for (int i = 0; i < addr_q.size(); i++)
            chk({tag, "_rd_addr_seq"}, 32'(addr_q[i]), 32'(i));
    endtask

    initial begin
        int cyc;
        int acc63;
        bit hit;
        int n_done;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; color_in = 1'b0;
        bif.out_ready = 1'b0;
        clear_board();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset_idle");

        // Empty board: 129 cycles, no pieces, full address walk
        clear_board();
        run_scan(1'b1, 0, -1, 1'b0, cyc, acc63);
        chk("empty_cycles", 32'(cyc), 32'd129);
        check_results(1'b1, "empty");

        // White pawn at 8 emitted, black knight at 10 skipped
        clear_board();
        board[8] = 6'b100010;
        board[10] = 6'b000001;
        run_scan(1'b1, 0, -1, 1'b0, cyc, acc63);
        chk("pawn_cycles", 32'(cyc), 32'd130);
        check_results(1'b1, "pawn");

        // Rooks at 0 and 63 with stalls; done right after last accept
        clear_board();
        board[0] = 6'b110000;
        board[63] = 6'b110000;
        run_scan(1'b1, 2, -1, 1'b0, cyc, acc63);
        chk("rook63_done_after_accept", 32'(cyc), 32'(acc63 + 1));
        check_results(1'b1, "rooks");

        // Black queen held, then aborted in HOLD
        clear_board();
        board[20] = 6'b011000;
        @(posedge clk); #1;
        color_in = 1'b0; start = 1'b1; bif.out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bif.out_valid) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("queen_valid_seen", 32'(hit), 32'd1);
        chk("queen_piece", 32'(bif.piece_reg), 32'h18);
        chk("queen_pos", 32'(bif.pos_reg), 32'd20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bif.out_ready = 1'b1;
        chk("abort_out_valid", 32'(bif.out_valid), 32'd0);
        chk("abort_piece_reg", 32'(bif.piece_reg), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(bif.rd_en), 32'd0);
        chk("abort_piece_count", 32'(piece_count), 32'd1);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        chk("abort_no_done_no_busy", 32'(n_done), 32'd0);

        // Abort and start together in IDLE: stay idle
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_rd_en", 32'(bif.rd_en), 32'd0);

        // Random boards and colours with random back-pressure
        for (int r = 0; r < 4; r++) begin
            logic clr;
            clr = 1'($urandom);
            random_board();
            run_scan(clr, 1, -1, 1'b0, cyc, acc63);
            check_results(clr, "random");
        end

        // Start pulsed mid-scan and during the done cycle: both ignored
        random_board();
        build_exp(1'b1);
        run_scan(1'b1, 0, 50, 1'b1, cyc, acc63);
        chk("midstart_cycles", 32'(cyc), 32'(129 + exp_q.size()));
        check_results(1'b1, "midstart");

        // Reset asserted while a read is in flight
        random_board();
        @(posedge clk); #1;
        color_in = 1'b1; start = 1'b1; bif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bif.rd_en) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midscan_req_seen", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk); #1;
        chk("reset_hold_rd_en", 32'(bif.rd_en), 32'd0);
        reset_n = 1'b1;
        color_in = 1'b0;
        run_scan(1'b0, 0, -1, 1'b0, cyc, acc63);
        build_exp(1'b0);
        chk("fresh_scan_cycles", 32'(cyc), 32'(129 + exp_q.size()));
        check_results(1'b0, "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
